// File: rtl/avr_io_uart_txfifo.sv
// ---------------------------------------------------------------------------
// avr_io_uart_txfifo
//
// Transmit byte FIFO between the CPU-side UDR write path and the
// avr_io_uart_tx serializer. Software can queue a burst of bytes, and the
// serializer is fed back-to-back through its prefetch slot, so no idle gap
// appears between stop bit and the next start bit.
//
// Optional feature macro: AVR_UART_TXFIFO_THRESH_EN
//   defined   : adds input thresh; thresh_irq is registered (level <= thresh)
//   undefined : no thresh port; thresh_irq tied to 0
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   wr_en        push strobe (CPU write to UDR)
//   wr_data      byte to push
//   flush        synchronous FIFO clear (dominates push and pop)
//   ovf_clr      clears the sticky overflow flag
//   tx_busy      serializer busy
//   tx_prefetch  serializer in its last-bit slot (accepts next byte)
//   thresh       level threshold (AVR_UART_TXFIFO_THRESH_EN only)
//   tx_strobe    FIFO non-empty, to serializer strobe (combinational)
//   tx_data      head byte, to serializer tx_in (combinational)
//   full         level == depth
//   empty        level == 0
//   level        current occupancy
//   overflow     sticky: a push was dropped
//   thresh_irq   level <= thresh (0 when the feature is disabled)
// ---------------------------------------------------------------------------
module avr_io_uart_txfifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic                  tx_busy,
  input  logic                  tx_prefetch,
`ifdef AVR_UART_TXFIFO_THRESH_EN
  input  logic [DEPTH_LOG2:0]   thresh,
`endif
  output logic                  tx_strobe,
  output logic [7:0]            tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  thresh_irq
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // Storage is deliberately not reset; tx_data is don't-care while empty.
  logic [7:0]    mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic          drop;

  // Handshake decode. full_q is the pre-pop state, so a write while full is
  // dropped even when the serializer takes a byte on the same edge.
  always_comb begin
    push = wr_en & ~full_q & ~flush;
    drop = wr_en &  full_q & ~flush;
    pop  = ~empty_q & (~tx_busy | tx_prefetch);
  end

  // Next-state for pointers, level, flags.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // Set wins over clear.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef AVR_UART_TXFIFO_THRESH_EN
  logic thresh_irq_q, thresh_irq_d;

  // Tracks next level so the flag moves on the same edge as level.
  always_comb begin
    thresh_irq_d = (level_d <= thresh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) thresh_irq_q <= 1'b0;
    else     thresh_irq_q <= thresh_irq_d;
  end

  assign thresh_irq = thresh_irq_q;
`else
  assign thresh_irq = 1'b0;
`endif

  // Head byte and strobe are zero-latency so the serializer samples the
  // byte on the same edge that pops it.
  assign tx_strobe = ~empty_q;
  assign tx_data   = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
